// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiply operand buffer: FSM state
// encoding, default geometry and the flat-bus lane slicing helper.
package mm_pkg;

   localparam int DEF_DATA_W  = 4;
   localparam int DEF_MAX_DIM = 3;

   // Buffer sequencing: load W, load X, stream K outer-product steps, pulse done.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD_W = 3'd1,
      ST_LOAD_X = 3'd2,
      ST_STREAM = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   // Bit position of the least significant bit of a lane on a flat bus;
   // lane 0 lives in the LSBs.
   function automatic int lane_lsb(input int lane, input int width);
      return lane * width;
   endfunction

endpackage

// File: rtl/mat_regfile.sv
// MAX_DIM*MAX_DIM element register array. One synchronous write port,
// synchronous clear, and a combinational read of MAX_DIM lanes taken at
// base, base+stride, base+2*stride, ... Disabled lanes and lanes whose
// address falls past the array read as zero.
module mat_regfile
   import mm_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int MAX_DIM = DEF_MAX_DIM,
   parameter int DIM_W   = $clog2(MAX_DIM + 1),
   parameter int AW      = $clog2(MAX_DIM * MAX_DIM)
) (
   input  logic                        clk,
   input  logic                        clear,
   input  logic                        we,
   input  logic [AW-1:0]               waddr,
   input  logic [DATA_W-1:0]           wdata,
   input  logic [AW-1:0]               base,
   input  logic [DIM_W-1:0]            stride,
   input  logic [MAX_DIM-1:0]          lane_en,
   output logic [MAX_DIM*DATA_W-1:0]   rdata
);

   localparam int DEPTH = MAX_DIM * MAX_DIM;

   logic [DATA_W-1:0] mem [DEPTH];

   // Clear wipes every entry; otherwise a write lands at waddr when in range.
   always_ff @(posedge clk) begin
      if (clear) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we && (int'(waddr) < DEPTH)) begin
         mem[waddr] <= wdata;
      end
   end

   // Strided lane read; each lane is forced to zero unless enabled.
   always_comb begin
      rdata = '0;
      for (int i = 0; i < MAX_DIM; i++) begin
         int addr;
         addr = int'(base) + i * int'(stride);
         if (lane_en[i] && (addr < DEPTH)) begin
            rdata[lane_lsb(i, DATA_W) +: DATA_W] = mem[addr[AW-1:0]];
         end
      end
   end

endmodule

// File: rtl/mem_bank_stream.sv
// Operand buffer for the MAC array. Loads W (rows_w x cols_w) and then
// X (rows_x x cols_x) row-major from one input stream, then emits one
// outer-product step per accepted beat: column k of W on data_outw and
// row k of X on data_outx, for k = 0 .. cols_w-1.
//
// Handshakes: a beat transfers on a rising edge where valid && ready.
// in_ready/out_valid never depend combinationally on in_valid/out_ready,
// and once out_valid is high the step data and step index hold steady
// until the beat is taken.
module mem_bank_stream
   import mm_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int MAX_DIM = DEF_MAX_DIM,
   parameter int DIM_W   = $clog2(MAX_DIM + 1)
) (
   input  logic                        clk,
   input  logic                        clear_mem,
   input  logic                        start,
   input  logic [DIM_W-1:0]            rows_w,
   input  logic [DIM_W-1:0]            cols_w,
   input  logic [DIM_W-1:0]            rows_x,
   input  logic [DIM_W-1:0]            cols_x,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [DATA_W-1:0]           data_in,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [MAX_DIM*DATA_W-1:0]   data_outw,
   output logic [MAX_DIM*DATA_W-1:0]   data_outx,
   output logic [DIM_W-1:0]            step,
   output logic                        ld_mac,
   output logic                        clear_mac,
   output logic                        last,
   output logic                        done,
   output logic                        busy,
   output logic                        dim_err
);

   localparam int AW = $clog2(MAX_DIM * MAX_DIM);

   state_t            state;
   logic [DIM_W-1:0]  rw, cw, rx, cx;
   logic [AW-1:0]     wcnt, xcnt;

   logic              in_fire, out_fire;
   logic              dims_ok;
   logic              w_last, x_last, k_last;
   logic              streaming;
   logic [MAX_DIM-1:0] w_en, x_en;
   logic [AW-1:0]     x_base;

   assign in_fire   = in_valid && in_ready;
   assign out_fire  = out_valid && out_ready;
   assign streaming = (state == ST_STREAM);

   assign dims_ok = (rows_w != '0) && (cols_w != '0) &&
                    (rows_x != '0) && (cols_x != '0) &&
                    (int'(rows_w) <= MAX_DIM) && (int'(cols_w) <= MAX_DIM) &&
                    (int'(rows_x) <= MAX_DIM) && (int'(cols_x) <= MAX_DIM) &&
                    (cols_w == rows_x);

   assign w_last = (int'(wcnt) == int'(rw) * int'(cw) - 1);
   assign x_last = (int'(xcnt) == int'(rx) * int'(cx) - 1);
   assign k_last = (step == cw - DIM_W'(1));

   assign ld_mac    = out_fire;
   assign clear_mac = out_valid && (step == '0);
   assign last      = out_valid && k_last;

   // Row k of X starts at k*cols_x; column k of W starts at k with stride cols_w.
   assign x_base = AW'(int'(step) * int'(cx));

   // Lane enables: only rows of W / columns of X that exist, only while streaming.
   always_comb begin
      w_en = '0;
      x_en = '0;
      for (int i = 0; i < MAX_DIM; i++) begin
         w_en[i] = streaming && (i < int'(rw));
         x_en[i] = streaming && (i < int'(cx));
      end
   end

   mat_regfile #(
      .DATA_W  (DATA_W),
      .MAX_DIM (MAX_DIM),
      .DIM_W   (DIM_W),
      .AW      (AW)
   ) u_w_mem (
      .clk     (clk),
      .clear   (clear_mem),
      .we      ((state == ST_LOAD_W) && in_fire),
      .waddr   (wcnt),
      .wdata   (data_in),
      .base    (AW'(step)),
      .stride  (cw),
      .lane_en (w_en),
      .rdata   (data_outw)
   );

   mat_regfile #(
      .DATA_W  (DATA_W),
      .MAX_DIM (MAX_DIM),
      .DIM_W   (DIM_W),
      .AW      (AW)
   ) u_x_mem (
      .clk     (clk),
      .clear   (clear_mem),
      .we      ((state == ST_LOAD_X) && in_fire),
      .waddr   (xcnt),
      .wdata   (data_in),
      .base    (x_base),
      .stride  (DIM_W'(1)),
      .lane_en (x_en),
      .rdata   (data_outx)
   );

   // Sequencer: state, latched dims, counters and registered status outputs.
   always_ff @(posedge clk) begin
      if (clear_mem) begin
         state     <= ST_IDLE;
         rw        <= '0;
         cw        <= '0;
         rx        <= '0;
         cx        <= '0;
         wcnt      <= '0;
         xcnt      <= '0;
         step      <= '0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         dim_err   <= 1'b0;
      end else begin
         done    <= 1'b0;
         dim_err <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (dims_ok) begin
                     rw       <= rows_w;
                     cw       <= cols_w;
                     rx       <= rows_x;
                     cx       <= cols_x;
                     wcnt     <= '0;
                     xcnt     <= '0;
                     step     <= '0;
                     in_ready <= 1'b1;
                     busy     <= 1'b1;
                     state    <= ST_LOAD_W;
                  end else begin
                     dim_err <= 1'b1;
                  end
               end
            end
            ST_LOAD_W: begin
               if (in_fire) begin
                  if (w_last) begin
                     wcnt  <= '0;
                     state <= ST_LOAD_X;
                  end else begin
                     wcnt <= wcnt + AW'(1);
                  end
               end
            end
            ST_LOAD_X: begin
               if (in_fire) begin
                  if (x_last) begin
                     xcnt      <= '0;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                     state     <= ST_STREAM;
                  end else begin
                     xcnt <= xcnt + AW'(1);
                  end
               end
            end
            ST_STREAM: begin
               if (out_fire) begin
                  if (k_last) begin
                     step      <= '0;
                     out_valid <= 1'b0;
                     done      <= 1'b1;
                     state     <= ST_DONE;
                  end else begin
                     step <= step + DIM_W'(1);
                  end
               end
            end
            ST_DONE: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               in_ready  <= 1'b0;
               out_valid <= 1'b0;
               busy      <= 1'b0;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bank_stream.sv
// Directed bench for mem_bank_stream: a 3x3/4-bit instance for the main
// scenarios and a 4x4/8-bit instance for the full-width case.
module tb_mem_bank_stream;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Expected {data_outw, data_outx} per step of the 3x3 instance.
   logic [23:0] exp_q[$];

   // Instance A: DATA_W=4, MAX_DIM=3
   logic        clear_mem, start, in_valid, out_ready;
   logic [1:0]  rows_w, cols_w, rows_x, cols_x;
   logic [3:0]  data_in;
   logic        in_ready, out_valid, ld_mac, clear_mac, last, done, busy, dim_err;
   logic [11:0] data_outw, data_outx;
   logic [1:0]  step;

   mem_bank_stream #(.DATA_W(4), .MAX_DIM(3)) dut_a (
      .clk(clk), .clear_mem(clear_mem), .start(start),
      .rows_w(rows_w), .cols_w(cols_w), .rows_x(rows_x), .cols_x(cols_x),
      .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .data_outw(data_outw), .data_outx(data_outx), .step(step),
      .ld_mac(ld_mac), .clear_mac(clear_mac), .last(last),
      .done(done), .busy(busy), .dim_err(dim_err)
   );

   // Instance B: DATA_W=8, MAX_DIM=4
   logic        clear_b, start_b, in_valid_b, out_ready_b;
   logic [2:0]  dim_b;
   logic [7:0]  data_in_b;
   logic        in_ready_b, out_valid_b, ld_mac_b, clear_mac_b, last_b, done_b, busy_b, dim_err_b;
   logic [31:0] outw_b, outx_b;
   logic [2:0]  step_b;

   mem_bank_stream #(.DATA_W(8), .MAX_DIM(4)) dut_b (
      .clk(clk), .clear_mem(clear_b), .start(start_b),
      .rows_w(dim_b), .cols_w(dim_b), .rows_x(dim_b), .cols_x(dim_b),
      .in_valid(in_valid_b), .in_ready(in_ready_b), .data_in(data_in_b),
      .out_valid(out_valid_b), .out_ready(out_ready_b),
      .data_outw(outw_b), .data_outx(outx_b), .step(step_b),
      .ld_mac(ld_mac_b), .clear_mac(clear_mac_b), .last(last_b),
      .done(done_b), .busy(busy_b), .dim_err(dim_err_b)
   );

   // ---------------- driver tasks ----------------
   task automatic reset_a();
      @(posedge clk); #1;
      clear_mem = 1'b1; start = 1'b0; in_valid = 1'b0;
      @(posedge clk); #1;
      clear_mem = 1'b0;
   endtask

   task automatic start_a(input logic [1:0] a, input logic [1:0] b,
                          input logic [1:0] c, input logic [1:0] d);
      rows_w = a; cols_w = b; rows_x = c; cols_x = d;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Idle for gap cycles (junk on data_in), then hold one beat until taken.
   task automatic beat_a(input logic [3:0] d, input int gap);
      bit ok;
      for (int g = 0; g < gap; g++) begin
         in_valid = 1'b0; data_in = 4'hF;
         @(posedge clk); #1;
      end
      in_valid = 1'b1; data_in = d;
      ok = 1'b0;
      for (int n = 0; n < 20 && !ok; n++) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (!ok) begin
         total++; bad++;
         $display("FAIL beat_timeout: in_ready stayed 0, required 1 within 20 cycles");
      end
   endtask

   // ---------------- scenario tasks ----------------
   task automatic test_reset();
      reset_a();
      @(negedge clk);
      total++;
      if ({in_ready, busy, out_valid, ld_mac, clear_mac, last, done, dim_err} !== 8'b0) begin
         bad++;
         $display("FAIL reset_ctrl: got %b required 00000000",
                  {in_ready, busy, out_valid, ld_mac, clear_mac, last, done, dim_err});
      end
      total++;
      if ({data_outw, data_outx, step} !== 26'b0) begin
         bad++;
         $display("FAIL reset_data: w=%h x=%h step=%0d required all 0", data_outw, data_outx, step);
      end
   endtask

   task automatic test_basic();
      logic [23:0] e;
      logic [5:0]  ec;
      out_ready = 1'b1;
      start_a(2'd3, 2'd3, 2'd3, 2'd3);
      for (int i = 0; i < 9; i++) beat_a(4'(i + 1), 0);
      for (int i = 0; i < 9; i++) beat_a((i % 4 == 0) ? 4'd1 : 4'd0, 0);
      exp_q = {24'h741_001, 24'h852_010, 24'h963_100};
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         e  = exp_q.pop_front();
         ec = {1'b1, 1'b1, (k == 0), (k == 2), 2'(k)};
         total++;
         if ({data_outw, data_outx} !== e) begin
            bad++;
            $display("FAIL basic_data k=%0d: w=%h x=%h required w=%h x=%h", k, data_outw, data_outx, e[23:12], e[11:0]);
         end
         total++;
         if ({out_valid, ld_mac, clear_mac, last, step} !== ec) begin
            bad++;
            $display("FAIL basic_ctrl k=%0d: got %b required %b", k, {out_valid, ld_mac, clear_mac, last, step}, ec);
         end
         @(posedge clk); #1;
      end
      @(negedge clk);
      total++;
      if ({done, out_valid, busy} !== 3'b101) begin
         bad++;
         $display("FAIL basic_done: {done,out_valid,busy}=%b required 101", {done, out_valid, busy});
      end
      @(posedge clk); #1;
      @(negedge clk);
      total++;
      if ({done, busy, in_ready} !== 3'b000) begin
         bad++;
         $display("FAIL basic_idle: {done,busy,in_ready}=%b required 000", {done, busy, in_ready});
      end
   endtask

   task automatic test_gaps();
      logic [3:0]  wv [6];
      logic [3:0]  xv [3];
      logic [23:0] e;
      logic [5:0]  ec;
      wv = '{4'd3, 4'd1, 4'd4, 4'd1, 4'd5, 4'd9};
      xv = '{4'd2, 4'd6, 4'd5};
      out_ready = 1'b1;
      start_a(2'd2, 2'd3, 2'd3, 2'd1);
      for (int i = 0; i < 6; i++) beat_a(wv[i], int'($urandom_range(0, 2)));
      for (int i = 0; i < 3; i++) beat_a(xv[i], int'($urandom_range(0, 2)));
      exp_q = {24'h013_002, 24'h051_006, 24'h094_005};
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         e  = exp_q.pop_front();
         ec = {1'b1, 1'b1, (k == 0), (k == 2), 2'(k)};
         total++;
         if ({data_outw, data_outx} !== e) begin
            bad++;
            $display("FAIL gaps_data k=%0d: w=%h x=%h required w=%h x=%h", k, data_outw, data_outx, e[23:12], e[11:0]);
         end
         total++;
         if ({out_valid, ld_mac, clear_mac, last, step} !== ec) begin
            bad++;
            $display("FAIL gaps_ctrl k=%0d: got %b required %b", k, {out_valid, ld_mac, clear_mac, last, step}, ec);
         end
         @(posedge clk); #1;
      end
      @(negedge clk);
      total++;
      if (done !== 1'b1) begin
         bad++;
         $display("FAIL gaps_done: done=%b required 1", done);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure();
      out_ready = 1'b1;
      start_a(2'd3, 2'd3, 2'd3, 2'd3);
      for (int i = 0; i < 9; i++) beat_a(4'(i + 1), 0);
      for (int i = 0; i < 9; i++) beat_a(4'(i + 1), 0);
      exp_q = {24'h741_321, 24'h852_654, 24'h963_987};
      @(negedge clk);
      total++;
      if ({data_outw, data_outx, step, ld_mac} !== {exp_q[0], 2'd0, 1'b1}) begin
         bad++;
         $display("FAIL bp_k0: w=%h x=%h step=%0d ld=%b required w=741 x=321 step=0 ld=1", data_outw, data_outx, step, ld_mac);
      end
      void'(exp_q.pop_front());
      @(posedge clk); #1;
      out_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         if (c == 1) begin
            start = 1'b1; rows_w = 2'd0;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         total++;
         if ({data_outw, data_outx, step, out_valid, ld_mac, dim_err} !== {exp_q[0], 2'd1, 1'b1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL bp_hold c=%0d: w=%h x=%h step=%0d valid=%b ld=%b err=%b required w=852 x=654 step=1 valid=1 ld=0 err=0",
                     c, data_outw, data_outx, step, out_valid, ld_mac, dim_err);
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      total++;
      if ({data_outw, data_outx, step, ld_mac} !== {exp_q[0], 2'd1, 1'b1}) begin
         bad++;
         $display("FAIL bp_k1: w=%h x=%h step=%0d ld=%b required w=852 x=654 step=1 ld=1", data_outw, data_outx, step, ld_mac);
      end
      void'(exp_q.pop_front());
      @(posedge clk); #1;
      @(negedge clk);
      total++;
      if ({data_outw, data_outx, step, last} !== {exp_q[0], 2'd2, 1'b1}) begin
         bad++;
         $display("FAIL bp_k2: w=%h x=%h step=%0d last=%b required w=963 x=987 step=2 last=1", data_outw, data_outx, step, last);
      end
      void'(exp_q.pop_front());
      @(posedge clk); #1;
      @(negedge clk);
      total++;
      if ({done, out_valid} !== 2'b10) begin
         bad++;
         $display("FAIL bp_done: {done,out_valid}=%b required 10", {done, out_valid});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_dim_err();
      logic [1:0] dv [2][4];
      dv = '{'{2'd3, 2'd3, 2'd2, 2'd3}, '{2'd0, 2'd1, 2'd1, 2'd1}};
      for (int t = 0; t < 2; t++) begin
         start_a(dv[t][0], dv[t][1], dv[t][2], dv[t][3]);
         @(negedge clk);
         total++;
         if ({dim_err, busy, in_ready} !== 3'b100) begin
            bad++;
            $display("FAIL dim_err_pulse t=%0d: {dim_err,busy,in_ready}=%b required 100", t, {dim_err, busy, in_ready});
         end
         @(posedge clk); #1;
         @(negedge clk);
         total++;
         if ({dim_err, busy, in_ready} !== 3'b000) begin
            bad++;
            $display("FAIL dim_err_after t=%0d: {dim_err,busy,in_ready}=%b required 000", t, {dim_err, busy, in_ready});
         end
      end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b1;
      start_a(2'd3, 2'd3, 2'd3, 2'd3);
      for (int i = 0; i < 9; i++) beat_a(4'(i + 1), 0);
      for (int i = 0; i < 2; i++) beat_a(4'(i + 3), 0);
      clear_mem = 1'b1;
      @(posedge clk); #1;
      clear_mem = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         total++;
         if ({busy, in_ready, out_valid, done} !== 4'b0000) begin
            bad++;
            $display("FAIL midreset_idle c=%0d: {busy,in_ready,out_valid,done}=%b required 0000", c, {busy, in_ready, out_valid, done});
         end
         @(posedge clk); #1;
      end
      start_a(2'd1, 2'd1, 2'd1, 2'd1);
      beat_a(4'd5, 0);
      beat_a(4'd7, 0);
      @(negedge clk);
      total++;
      if ({data_outw, data_outx} !== {12'h005, 12'h007}) begin
         bad++;
         $display("FAIL one_data: w=%h x=%h required w=005 x=007", data_outw, data_outx);
      end
      total++;
      if ({out_valid, ld_mac, clear_mac, last, step} !== 6'b111100) begin
         bad++;
         $display("FAIL one_ctrl: got %b required 111100", {out_valid, ld_mac, clear_mac, last, step});
      end
      @(posedge clk); #1;
      @(negedge clk);
      total++;
      if (done !== 1'b1) begin
         bad++;
         $display("FAIL one_done: done=%b required 1", done);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_max_dim();
      bit         ok;
      logic [7:0] ec;
      clear_b = 1'b1; start_b = 1'b0; in_valid_b = 1'b0; out_ready_b = 1'b1;
      dim_b = 3'd4; data_in_b = 8'h00;
      @(posedge clk); #1;
      clear_b = 1'b0;
      start_b = 1'b1;
      @(posedge clk); #1;
      start_b = 1'b0;
      for (int i = 0; i < 32; i++) begin
         in_valid_b = 1'b1; data_in_b = 8'hFF;
         ok = 1'b0;
         for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            ok = in_ready_b;
            @(posedge clk); #1;
         end
         if (!ok) begin
            total++; bad++;
            $display("FAIL max_beat_timeout i=%0d: in_ready=0 required 1", i);
         end
      end
      in_valid_b = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         ec = {1'b1, 1'b1, (k == 0), (k == 3), 1'b0, 3'(k)};
         total++;
         if ({outw_b, outx_b} !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            bad++;
            $display("FAIL max_data k=%0d: w=%h x=%h required all ff", k, outw_b, outx_b);
         end
         total++;
         if ({out_valid_b, ld_mac_b, clear_mac_b, last_b, dim_err_b, step_b} !== ec) begin
            bad++;
            $display("FAIL max_ctrl k=%0d: got %b required %b", k, {out_valid_b, ld_mac_b, clear_mac_b, last_b, dim_err_b, step_b}, ec);
         end
         @(posedge clk); #1;
      end
      @(negedge clk);
      total++;
      if ({done_b, busy_b, out_valid_b} !== 3'b110) begin
         bad++;
         $display("FAIL max_done: {done,busy,out_valid}=%b required 110", {done_b, busy_b, out_valid_b});
      end
      @(posedge clk); #1;
   endtask

   initial begin
      clear_mem = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      rows_w = '0; cols_w = '0; rows_x = '0; cols_x = '0; data_in = '0;
      clear_b = 1'b1; start_b = 1'b0; in_valid_b = 1'b0; out_ready_b = 1'b0;
      dim_b = '0; data_in_b = '0;
      test_reset();
      test_basic();
      test_gaps();
      test_backpressure();
      test_dim_err();
      test_reset_mid();
      test_max_dim();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
